// File: rtl/data_controller_pkg.sv
// Shared constants and types for the sample packetiser: header sync word,
// packet FSM states and the test-pattern word builder.
package data_controller_pkg;

  localparam logic [15:0] HDR_SYNC = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_e;

  // Test pattern word: counter in the upper half, its complement in the lower.
  function automatic logic [31:0] test_word(input logic [15:0] cnt);
    return {cnt, ~cnt};
  endfunction

endpackage

// File: rtl/data_controller_sync_fifo.sv
// Synchronous FIFO with full/empty flags. Reads are first-word-fall-through
// from registered storage; a write while full succeeds if a read happens too.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_ok, rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rd_ok    = rd_en & ~empty;
    wr_ok    = wr_en & (~full | rd_ok);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_ok};
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/data_controller.sv
// Packetiser: buffers I/Q samples (or a test pattern) and emits packets of a
// sync/sequence header followed by PKT_SAMPLES payload words on a ready/valid port.
module data_controller
  import data_controller_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int PKT_SAMPLES = 64,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_mode,
  input  logic [SAMPLE_W-1:0]   s_i,
  input  logic [SAMPLE_W-1:0]   s_q,
  input  logic                  s_valid,
  output logic [2*SAMPLE_W-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           ovf_cnt
);

  localparam int DW = 2 * SAMPLE_W;
  localparam int CW = $clog2(PKT_SAMPLES + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [15:0]     seq_q, seq_d;
  logic [15:0]     ovf_cnt_q, ovf_cnt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   pay_cnt_q, pay_cnt_d;

  logic            fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [DW-1:0]   fifo_wdata, fifo_rdata;
  logic            out_free, wr_accept;
  logic [15:0]     cnt_cur;

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    seq_d     = seq_q;
    pay_cnt_d = pay_cnt_q;
    fifo_rd   = 1'b0;
    // The output register may be reloaded when empty or when its word leaves.
    out_free  = ~m_valid_q | m_ready;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          m_data_d  = DW'({HDR_SYNC, seq_q});
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          pay_cnt_d = '0;
          state_d   = HEADER;
        end
      end
      HEADER, PAYLOAD: begin
        if (out_free) begin
          state_d = PAYLOAD;
          if (m_last_q) begin
            seq_d     = seq_q + 16'd1;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = IDLE;
          end else if (!fifo_empty) begin
            fifo_rd   = 1'b1;
            m_data_d  = fifo_rdata;
            m_valid_d = 1'b1;
            m_last_d  = (pay_cnt_q == CW'(PKT_SAMPLES - 1));
            pay_cnt_d = pay_cnt_q + CW'(1);
          end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Source selection only follows test_mode between packets; a switch restarts the pattern.
    mode_d     = (state_q == IDLE) ? test_mode : mode_q;
    cnt_cur    = (mode_d != mode_q) ? 16'h0000 : cnt_q;
    cnt_d      = cnt_cur;
    ovf_cnt_d  = ovf_cnt_q;
    wr_accept  = ~fifo_full | fifo_rd;
    fifo_wr    = 1'b0;
    fifo_wdata = {s_i, s_q};

    if (mode_d) begin
      fifo_wr    = wr_accept;
      fifo_wdata = DW'(test_word(cnt_cur));
      if (wr_accept) cnt_d = cnt_cur + 16'd1;
    end else if (s_valid) begin
      if (wr_accept) fifo_wr = 1'b1;
      else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      seq_q     <= '0;
      ovf_cnt_q <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      pay_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      seq_q     <= seq_d;
      ovf_cnt_q <= ovf_cnt_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pay_cnt_q <= pay_cnt_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_data_controller.sv
// Directed bench for data_controller: a per-cycle vector table for the basic
// external-mode flow, then hand-written overflow, reset, pattern and wrap sequences.
module tb_data_controller;

  localparam int SW  = 16;
  localparam int PKT = 64;
  localparam int FD  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          test_mode = 1'b0;
  logic [SW-1:0] s_i = '0;
  logic [SW-1:0] s_q = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [15:0]   ovf_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the output stream: position inside the packet, seq and pattern counter.
  int          exp_pos = 0;
  logic [15:0] exp_seq = 16'h0000;
  logic [15:0] exp_cnt = 16'h0000;

  data_controller #(
    .SAMPLE_W    (SW),
    .PKT_SAMPLES (PKT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .test_mode (test_mode),
    .s_i       (s_i),
    .s_q       (s_q),
    .s_valid   (s_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        s_valid;
    logic [15:0] si;
    logic [15:0] sq;
    logic        ready;
    logic        exp_valid;
    logic        exp_last;
    logic [31:0] exp_data;
    logic [15:0] exp_ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives m_ready each cycle and checks every transfer against the model.
  task automatic run_stream(input int n_xfers, input bit rnd);
    int          got = 0;
    int          cycles = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] exp_w;
    logic        exp_l;
    while (got < n_xfers && cycles < n_xfers * 8 + 200) begin
      @(negedge clk);
      cycles++;
      if (prev_stall)
        check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      m_ready = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (m_valid && m_ready) begin
        if (exp_pos == 0) begin
          exp_w = {16'hA5A5, exp_seq};
          exp_l = 1'b0;
          check("header", {m_last, m_data}, {exp_l, exp_w});
        end else begin
          exp_w = {exp_cnt, ~exp_cnt};
          exp_l = (exp_pos == PKT);
          check("payload", {m_last, m_data}, {exp_l, exp_w});
          exp_cnt = exp_cnt + 16'd1;
        end
        if (exp_pos == PKT) begin
          exp_pos = 0;
          exp_seq = exp_seq + 16'd1;
        end else begin
          exp_pos++;
        end
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    if (got < n_xfers) check("stream_timeout", 64'(got), 64'(n_xfers));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          got;
    logic [31:0] exp_w;
    logic [15:0] k16;

    //            rst  sv   s_i      s_q      rdy  vld  last data           ovf
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h00000000, 16'h0};
    vecs[1] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 32'h00000000, 16'h0};
    vecs[2] = '{1'b1, 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, 1'b0, 32'hA5A50000, 16'h0};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 32'hA5A50000, 16'h0};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h11112222, 16'h0};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h33334444, 16'h0};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h33334444, 16'h0};
    vecs[7] = '{1'b1, 1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, 32'h33334444, 16'h0};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h55556666, 16'h0};
    vecs[9] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h55556666, 16'h0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst     = vecs[i].rst;
      s_valid = vecs[i].s_valid;
      s_i     = vecs[i].si;
      s_q     = vecs[i].sq;
      m_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d", i), {m_valid, m_last, m_data, ovf_cnt},
            {vecs[i].exp_valid, vecs[i].exp_last, vecs[i].exp_data, vecs[i].exp_ovf});
    end

    // Reset while a payload word is being presented.
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_payload", {m_valid, m_last, m_data, ovf_cnt}, 64'h0);
    rst = 1'b1;

    // Overflow: 40 samples against a stalled output, 16 fit and 24 drop.
    for (int k = 0; k < 40; k++) begin
      s_valid = 1'b1;
      s_i = 16'h0100 + 16'(k);
      s_q = 16'hC000 + 16'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("ovf_after_40", ovf_cnt, 16'd24);

    m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 17; c++) begin
      if (m_valid) begin
        if (got == 0) begin
          exp_w = 32'hA5A50000;
        end else begin
          k16   = 16'(got - 1);
          exp_w = {16'h0100 + k16, 16'hC000 + k16};
        end
        check($sformatf("drain%0d", got), {m_last, m_data}, {1'b0, exp_w});
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", 64'(got), 64'd17);
    check("drain_then_idle_valid", m_valid, 1'b0);

    // Reset clears the overflow count; then fill, force to the top, drop one more.
    rst = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    check("rst_clears_all", {m_valid, m_last, m_data, ovf_cnt}, 64'h0);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      s_i = 16'(k);
      s_q = 16'(k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("ovf_after_20", ovf_cnt, 16'd4);
    force dut.ovf_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.ovf_cnt_q;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    check("ovf_saturate", ovf_cnt, 16'hFFFF);
    check("stalled_header_hold", {m_valid, m_data}, {1'b1, 32'hA5A50000});

    // Test pattern from reset with m_ready held high: one full packet and the next header.
    rst = 1'b0; test_mode = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    exp_pos = 0; exp_seq = 16'h0000; exp_cnt = 16'h0000;
    run_stream(PKT + 2, 1'b0);
    check("second_header_seen", 64'(exp_seq), 64'd1);

    // Random backpressure: counter continuity and stall stability.
    run_stream(300, 1'b1);

    // Sequence wrap: jump seq to 0xFFFF mid-packet and watch the next two headers.
    while (exp_pos < 5 || exp_pos > 60) run_stream(1, 1'b0);
    force dut.seq_q = 16'hFFFF;
    exp_seq = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    m_ready = 1'b0;
    run_stream(140, 1'b0);
    check("seq_wrapped", 64'(exp_seq), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_controller.md
DATA_CONTROLLER -- requirements
Module: data_controller

Interface
REQ-001 Parameter SAMPLE_W, default 16: width of each I and Q sample.
REQ-002 Parameter PKT_SAMPLES, default 64: number of payload words per packet, range 2..1024.
REQ-003 Parameter FIFO_DEPTH, default 16: input buffer depth, a power of two.
REQ-004 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low.
REQ-006 Port test_mode, input, 1: 1 selects the internal pattern source; 0 selects the external sample input.
REQ-007 Port s_i, input, SAMPLE_W: external I sample.
REQ-008 Port s_q, input, SAMPLE_W: external Q sample.
REQ-009 Port s_valid, input, 1: external sample strobe; there is no backpressure.
REQ-010 Port m_data, output, 2*SAMPLE_W: output word.
REQ-011 Port m_valid, output, 1: m_data is valid.
REQ-012 Port m_ready, input, 1: downstream accepts a word.
REQ-013 Port m_last, output, 1: marks the final word of a packet.
REQ-014 Port ovf_cnt, output, 16: count of dropped samples.

Function
REQ-015 A word transfers on a cycle with m_valid=1 and m_ready=1; m_data, m_valid and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-016 External mode: each cycle with s_valid=1 SHALL write {s_i,s_q} (I in the MSBs) to the FIFO if it is not full; otherwise the sample is dropped and ovf_cnt increments, saturating at 0xFFFF.
REQ-017 Test mode: a 16-bit counter SHALL write {cnt, ~cnt} each cycle the FIFO is not full and then increment, wrapping to 0; s_valid is ignored and no drops occur.
REQ-018 The test counter SHALL restart at 0 whenever test_mode changes; a test_mode change takes effect only at a packet boundary, when the FSM is in IDLE.
REQ-019 The FSM SHALL have three states: IDLE, HEADER, PAYLOAD.
REQ-020 IDLE -> HEADER when the FIFO is non-empty.
REQ-021 HEADER SHALL present m_data = {16'hA5A5, seq} with m_last=0, then go to PAYLOAD on transfer.
REQ-022 PAYLOAD SHALL pop one FIFO word per transfer; m_valid=0 while the FIFO is empty.
REQ-023 m_last=1 SHALL be asserted on the PKT_SAMPLES-th payload word; on its transfer seq increments (wrapping 0xFFFF->0) and the FSM returns to IDLE.
REQ-024 Simultaneous FIFO write and read SHALL both succeed, including when the FIFO is full (no drop) or empty (no bypass).
REQ-025 All outputs SHALL be registered.
REQ-026 Latency: a sample written on cycle N SHALL be presentable on m_data no earlier than N+2.

Reset
REQ-027 While rst=0 at a clock edge: FSM=IDLE, FIFO empty, seq=0, ovf_cnt=0, test counter=0, m_valid=0, m_last=0, m_data=0.
REQ-028 Reset mid-packet SHALL abandon the packet with no m_last; the first packet after reset carries seq=0.

Structure
REQ-029 Package data_controller_pkg SHALL hold the HDR_SYNC constant (16'hA5A5) and the FSM state enum.
REQ-030 The FIFO SHALL be a sub-module sync_fifo (parameters: width, depth) with full/empty flags.

Verification
REQ-031 test_mode=1, m_ready=1 after reset -> first word 0xA5A50000, then payload 0x0000FFFF, 0x0001FFFE, ...; m_last on word 65; second header 0xA5A50001.
REQ-032 External mode, s_valid every cycle, m_ready=0 for 40 cycles -> 16 samples buffered, ovf_cnt=24, and the accepted samples are output in order.
REQ-033 Random m_ready toggling in test mode -> no gaps or duplicates in the counter sequence, and m_data stays stable while stalled.
REQ-034 rst=0 pulse in mid-PAYLOAD -> all outputs return to 0 the next cycle, and the next header is 0xA5A50000.
REQ-035 Force seq to 0xFFFF -> that header is 0xA5A5FFFF and the following header is 0xA5A50000.
REQ-036 Saturation: force ovf_cnt to 0xFFFF, then drop one more sample -> ovf_cnt remains 0xFFFF.
